async_fifo: RTL and testbench

ASYNC_FIFO -- requirements
Module: async_fifo

---
 rtl/async_fifo_pkg.sv | 12 +
 rtl/async_fifo_sync_2ff.sv | 26 ++
 rtl/async_fifo.sv | 80 ++++++++
 tb/tb_async_fifo.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared defaults and pointer encoding helpers for the FIFO.
package async_fifo_pkg;

   localparam int WIDTH_DEF  = 4;
   localparam int ADDR_W_DEF = 3;

   // Callers cast the result back to their own pointer width.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/async_fifo_sync_2ff.sv
// Two-flop synchronizer carrying a Gray pointer across to the other side.
module sync_2ff #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/async_fifo.sv
// Gray-pointer FIFO with 2-flop pointer synchronizers; flags are pessimistic
// so the FIFO never overflows or underflows.
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic             wclk,
   input  logic             wreset,
   input  logic [WIDTH-1:0] wdata,
   input  logic             wen,
   input  logic             ren,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW    = ADDR_W + 1;
   localparam int DEPTH = 1 << ADDR_W;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0]    wptr_q, wptr_d, wgray_q, wgray_d;
   logic [PW-1:0]    rptr_q, rptr_d, rgray_q, rgray_d;
   logic [PW-1:0]    rq2_wgray, wq2_rgray;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             wr_acc, rd_acc;

   // Flags depend only on registered pointers, never on wen/ren.
   assign empty = (rgray_q == rq2_wgray);
   assign full  = (wgray_q == {~wq2_rgray[PW-1:PW-2], wq2_rgray[PW-3:0]});

   always_comb begin
      wr_acc  = wen && !full;
      rd_acc  = ren && !empty;
      wptr_d  = wptr_q + PW'(wr_acc);
      rptr_d  = rptr_q + PW'(rd_acc);
      wgray_d = PW'(bin2gray(32'(wptr_d)));
      rgray_d = PW'(bin2gray(32'(rptr_d)));
      rdata_d = rd_acc ? mem_q[rptr_q[ADDR_W-1:0]] : rdata_q;
   end

   always_ff @(posedge wclk or posedge wreset) begin
      if (wreset) begin
         wptr_q  <= '0;
         wgray_q <= '0;
         rptr_q  <= '0;
         rgray_q <= '0;
         rdata_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         wgray_q <= wgray_d;
         rptr_q  <= rptr_d;
         rgray_q <= rgray_d;
         rdata_q <= rdata_d;
      end
   end

   always_ff @(posedge wclk) begin
      if (wr_acc) mem_q[wptr_q[ADDR_W-1:0]] <= wdata;
   end

   sync_2ff #(.W(PW)) u_sync_w2r (
      .clk (wclk),
      .rst (wreset),
      .d   (wgray_q),
      .q   (rq2_wgray)
   );

   sync_2ff #(.W(PW)) u_sync_r2w (
      .clk (wclk),
      .rst (wreset),
      .d   (rgray_q),
      .q   (wq2_rgray)
   );

   assign rdata = rdata_q;

endmodule

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, single word, fill, drain, wrap, mid-op reset.
module tb_async_fifo;

   logic       wclk = 1'b0;
   logic       wreset, wen, ren;
   logic [3:0] wdata, rdata;
   logic       full, empty;

   int errors = 0;
   int checks = 0;

   logic [3:0] fill_v [10];
   logic [3:0] wr4_v  [4];
   logic [3:0] cc_v   [8];

   always #5 wclk = ~wclk;

   async_fifo #(.WIDTH(4), .ADDR_W(3)) dut (
      .wclk   (wclk),
      .wreset (wreset),
      .wdata  (wdata),
      .wen    (wen),
      .ren    (ren),
      .rdata  (rdata),
      .full   (full),
      .empty  (empty)
   );

   task automatic cycle();
      @(posedge wclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      fill_v = '{4'h3, 4'h7, 4'hC, 4'h1, 4'hE, 4'h5, 4'h9, 4'h2, 4'h6, 4'hB};
      wr4_v  = '{4'h4, 4'h8, 4'hD, 4'h7};
      cc_v   = '{4'hA, 4'h3, 4'h6, 4'h9, 4'hC, 4'hF, 4'h2, 4'h5};

      wreset = 1'b1; wen = 1'b0; ren = 1'b0; wdata = 4'h0;
      #20;
      chk("rst_hold_empty", 8'(empty), 8'h1);
      chk("rst_hold_full", 8'(full), 8'h0);
      #30;
      wreset = 1'b0;
      #1;
      chk("rst_empty", 8'(empty), 8'h1);
      chk("rst_full", 8'(full), 8'h0);
      chk("rst_rdata", 8'(rdata), 8'h0);

      // single word: empty clears only after two synchronizer edges
      wdata = 4'hA; wen = 1'b1;
      cycle();
      wen = 1'b0;
      chk("sw_empty_k", 8'(empty), 8'h1);
      cycle();
      chk("sw_empty_k1", 8'(empty), 8'h1);
      cycle();
      chk("sw_empty_k2", 8'(empty), 8'h0);
      ren = 1'b1;
      cycle();
      ren = 1'b0;
      chk("sw_rdata", 8'(rdata), 8'hA);
      chk("sw_empty_after", 8'(empty), 8'h1);
      cycle(); cycle();

      // fill with 10 words: only 8 fit
      wen = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wdata = fill_v[i];
         cycle();
         chk($sformatf("fill_full_%0d", i), 8'(full), (i >= 7) ? 8'h1 : 8'h0);
      end
      wen = 1'b0;
      chk("fill_empty", 8'(empty), 8'h0);

      // drain 9 times: 9th read ignored, rdata holds last word
      ren = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cycle();
         chk($sformatf("drain_rdata_%0d", i), 8'(rdata), 8'(fill_v[(i > 7) ? 7 : i]));
         chk($sformatf("drain_empty_%0d", i), 8'(empty), (i >= 7) ? 8'h1 : 8'h0);
      end
      ren = 1'b0;
      cycle(); cycle();
      chk("drain_full", 8'(full), 8'h0);

      // four writes then four reads
      wen = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wdata = wr4_v[i];
         cycle();
      end
      wen = 1'b0;
      cycle(); cycle();
      ren = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("wr4_rdata_%0d", i), 8'(rdata), 8'(wr4_v[i]));
      end
      ren = 1'b0;
      chk("wr4_empty", 8'(empty), 8'h1);
      cycle(); cycle();

      // concurrent writes and reads across the pointer wrap
      ren = 1'b1;
      for (int i = 0; i < 11; i++) begin
         wen = (i < 8);
         if (i < 8) wdata = cc_v[i];
         cycle();
         chk($sformatf("cc_rdata_%0d", i), 8'(rdata), 8'((i < 3) ? wr4_v[3] : cc_v[i-3]));
         chk($sformatf("cc_full_%0d", i), 8'(full), 8'h0);
         chk($sformatf("cc_empty_%0d", i), 8'(empty), ((i < 2) || (i == 10)) ? 8'h1 : 8'h0);
      end
      wen = 1'b0; ren = 1'b0;

      // mid-operation reset discards stored words
      wen = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         wdata = 4'(i);
         cycle();
      end
      wen = 1'b0;
      cycle(); cycle();
      chk("mid_empty_pre", 8'(empty), 8'h0);
      #2;
      wreset = 1'b1;
      #1;
      chk("mid_rst_empty", 8'(empty), 8'h1);
      chk("mid_rst_full", 8'(full), 8'h0);
      chk("mid_rst_rdata", 8'(rdata), 8'h0);
      cycle();
      wreset = 1'b0;
      wdata = 4'h9; wen = 1'b1;
      cycle();
      wen = 1'b0;
      cycle(); cycle();
      chk("post_empty", 8'(empty), 8'h0);
      ren = 1'b1;
      cycle();
      ren = 1'b0;
      chk("post_rdata", 8'(rdata), 8'h9);
      chk("post_empty_after", 8'(empty), 8'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
